// File: rtl/fp32_multiplication.sv
// fp32_multiplication: pipelined IEEE-754 single-precision multiplier (FMUL.S), 4-cycle latency
// Ports: clk; rst_n (async, active-high reset); start qualifies a_in/b_in;
//        result/Exception registered, valid while done is high.
// Build option: define FMUL_ROUND_RNE_EN for round-to-nearest-even, otherwise truncation.
module fp32_multiplication (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] result,
    output logic        done,
    output logic        Exception
);
    logic        r0_v;
    logic [31:0] r0_a, r0_b;
    logic        r1_v, r1_s, r1_nan, r1_inf, r1_zero;
    logic [7:0]  r1_ea, r1_eb;
    logic [23:0] r1_ma, r1_mb;
    logic        r2_v, r2_s, r2_nan, r2_inf, r2_zero;
    logic [9:0]  r2_exp;
`ifdef FMUL_ROUND_RNE_EN
    logic [25:0] r2_top;
    logic        r2_st;
    logic [47:0] w_prod;
`else
    logic [24:0] r2_top;
`endif
    logic        r3_v, r3_s, r3_nan, r3_inf, r3_zero;
    logic [9:0]  r3_exp;
    logic [22:0] r3_frac;
    logic        w_a_zero, w_b_zero, w_a_max, w_b_max, w_a_fz, w_b_fz;
    logic        w_hi, w_inv, w_ovf, w_udf, w_exc;
    logic [22:0] w_frac_r;
    logic [9:0]  w_exp_r;
    logic [31:0] w_res;
`ifdef FMUL_ROUND_RNE_EN
    logic        w_g, w_st, w_inc;
    logic [22:0] w_frac;
    logic [23:0] w_rnd;
    assign w_prod = r1_ma * r1_mb;
`endif
    // Subnormals have a zero exponent field and are therefore flushed to zero here.
    assign w_a_zero = r0_a[30:23] == 8'h00;
    assign w_b_zero = r0_b[30:23] == 8'h00;
    assign w_a_max  = r0_a[30:23] == 8'hFF;
    assign w_b_max  = r0_b[30:23] == 8'hFF;
    assign w_a_fz   = r0_a[22:0] == 23'd0;
    assign w_b_fz   = r0_b[22:0] == 23'd0;
    always_comb begin
`ifdef FMUL_ROUND_RNE_EN
        // r2_top holds product bits [47:22]; lower bits live only in the sticky r2_st.
        w_hi     = r2_top[25];
        w_frac   = w_hi ? r2_top[24:2] : r2_top[23:1];
        w_g      = w_hi ? r2_top[1] : r2_top[0];
        w_st     = w_hi ? (r2_top[0] | r2_st) : r2_st;
        w_inc    = w_g & (w_st | w_frac[0]);
        w_rnd    = {1'b0, w_frac} + {23'd0, w_inc};
        // A carry out of the fraction means 1.111..+ulp = 10.000.., so the fraction wraps to zero.
        w_frac_r = w_rnd[22:0];
        w_exp_r  = r2_exp + {9'd0, w_hi} + {9'd0, w_rnd[23]};
`else
        // r2_top holds product bits [47:23].
        w_hi     = r2_top[24];
        w_frac_r = w_hi ? r2_top[23:1] : r2_top[22:0];
        w_exp_r  = r2_exp + {9'd0, w_hi};
`endif
        w_inv = r3_nan | (r3_inf & r3_zero);
        w_ovf = $signed(r3_exp) >= 10'sd255;
        w_udf = $signed(r3_exp) <= 10'sd0;
        w_res = w_inv   ? 32'h7FC00000 :
                r3_inf  ? {r3_s, 8'hFF, 23'd0} :
                r3_zero ? {r3_s, 31'd0} :
                w_ovf   ? {r3_s, 8'hFF, 23'd0} :
                w_udf   ? {r3_s, 31'd0} :
                          {r3_s, r3_exp[7:0], r3_frac};
        w_exc = w_inv | (~r3_inf & ~r3_zero & (w_ovf | w_udf));
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r0_v <= 1'b0; r0_a <= '0; r0_b <= '0;
            r1_v <= 1'b0; r1_s <= 1'b0; r1_nan <= 1'b0; r1_inf <= 1'b0; r1_zero <= 1'b0;
            r1_ea <= '0; r1_eb <= '0; r1_ma <= '0; r1_mb <= '0;
            r2_v <= 1'b0; r2_s <= 1'b0; r2_nan <= 1'b0; r2_inf <= 1'b0; r2_zero <= 1'b0;
            r2_exp <= '0; r2_top <= '0;
`ifdef FMUL_ROUND_RNE_EN
            r2_st <= 1'b0;
`endif
            r3_v <= 1'b0; r3_s <= 1'b0; r3_nan <= 1'b0; r3_inf <= 1'b0; r3_zero <= 1'b0;
            r3_exp <= '0; r3_frac <= '0;
            result <= '0; done <= 1'b0; Exception <= 1'b0;
        end else begin
            r0_v    <= start;
            r0_a    <= a_in;
            r0_b    <= b_in;
            r1_v    <= r0_v;
            r1_s    <= r0_a[31] ^ r0_b[31];
            r1_nan  <= (w_a_max & ~w_a_fz) | (w_b_max & ~w_b_fz);
            r1_inf  <= (w_a_max & w_a_fz) | (w_b_max & w_b_fz);
            r1_zero <= w_a_zero | w_b_zero;
            r1_ea   <= r0_a[30:23];
            r1_eb   <= r0_b[30:23];
            r1_ma   <= w_a_zero ? 24'd0 : {1'b1, r0_a[22:0]};
            r1_mb   <= w_b_zero ? 24'd0 : {1'b1, r0_b[22:0]};
            r2_v    <= r1_v;
            r2_s    <= r1_s;
            r2_nan  <= r1_nan;
            r2_inf  <= r1_inf;
            r2_zero <= r1_zero;
            r2_exp  <= {2'b00, r1_ea} + {2'b00, r1_eb} - 10'd127;
`ifdef FMUL_ROUND_RNE_EN
            r2_top  <= w_prod[47:22];
            r2_st   <= |w_prod[21:0];
`else
            r2_top  <= 25'((48'(r1_ma) * 48'(r1_mb)) >> 23);
`endif
            r3_v    <= r2_v;
            r3_s    <= r2_s;
            r3_nan  <= r2_nan;
            r3_inf  <= r2_inf;
            r3_zero <= r2_zero;
            r3_exp  <= w_exp_r;
            r3_frac <= w_frac_r;
            done    <= r3_v;
            if (r3_v) begin
                result    <= w_res;
                Exception <= w_exc;
            end
        end
    end
endmodule

// File: tb/tb_fp32_multiplication.sv
// tb_fp32_multiplication: directed-vector self-checking bench for fp32_multiplication
module tb_fp32_multiplication;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [31:0] result;
    logic        done;
    logic        Exception;
    int          n_checks = 0;
    int          n_errors = 0;

    fp32_multiplication dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .result(result), .done(done), .Exception(Exception)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample at edge N; done must stay low after N+1..N+3 and be high after N+4.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0; a_in = $urandom; b_in = $urandom;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check({tag, "_early_done"}, {31'd0, done}, 32'd0);
        end
        @(posedge clk); #1;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_result"}, result, er);
        check({tag, "_exc"}, {31'd0, Exception}, {31'd0, ee});
        @(posedge clk); #1;
        check({tag, "_done_clear"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic [31:0] tr [3];
        ta = '{32'h40000000, 32'h40800000, 32'h41200000};
        tb = '{32'h40400000, 32'h3F000000, 32'h41200000};
        tr = '{32'h40C00000, 32'h40000000, 32'h42C80000};
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_exc", {31'd0, Exception}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;

        run_op("basic", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0);
        run_op("sign", 32'hBFC00000, 32'h40000000, 32'hC0400000, 1'b0);
        run_op("zero", 32'h42C80000, 32'h00000000, 32'h00000000, 1'b0);
        run_op("negzero", 32'h80000000, 32'h40A00000, 32'h80000000, 1'b0);
        run_op("subnorm_ftz", 32'h00000001, 32'h40000000, 32'h00000000, 1'b0);
        run_op("inf_times_2", 32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0);
        run_op("neg_inf", 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0);
        run_op("nan", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b1);
        run_op("underflow", 32'h00800000, 32'h00800000, 32'h00000000, 1'b1);
`ifdef FMUL_ROUND_RNE_EN
        run_op("round_tie", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 1'b0);
`else
        run_op("round_tie", 32'h3F800001, 32'h3FC00000, 32'h3FC00001, 1'b0);
`endif

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; a_in = ta[i]; b_in = tb[i];
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("tput_early", {31'd0, done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("tput_done%0d", i), {31'd0, done}, 32'd1);
            check($sformatf("tput_res%0d", i), result, tr[i]);
        end
        @(posedge clk); #1;
        check("tput_end", {31'd0, done}, 32'd0);

        run_op("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1);
        run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1);

        @(negedge clk);
        start = 1'b1; a_in = 32'h3FC00000; b_in = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b1;
        #1;
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_exc", {31'd0, Exception}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("rst_flush_done%0d", k), {31'd0, done}, 32'd0);
            check($sformatf("rst_flush_res%0d", k), result, 32'h0);
        end
        run_op("after_rst", 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
